// File: rtl/perf_counter_unit.sv
// Performance monitor: cycle, retired-instruction and event counters between start and done, frozen on done's rising edge.
// Optional PERF_SATURATE_EN: counters saturate at all-ones instead of wrapping. rd_data has 1-cycle latency; no backpressure.
module perf_counter_unit #(
  parameter int CNT_W   = 16,
  parameter int NUM_EVT = 4,
  parameter int SEL_W   = 3
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               start,
  input  logic               done,
  input  logic               instr_retire,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               clear,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [CNT_W-1:0]   clock_count,
  output logic [CNT_W-1:0]   instr_cnt,
  output logic               running,
  output logic               frozen,
  output logic [NUM_EVT+1:0] ovf
);

  localparam int NCNT = NUM_EVT + 2;

  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             done_q;
  logic             done_edge;
  logic [NCNT-1:0]  inc;
  logic [CNT_W-1:0] cnt [NCNT];
  logic [CNT_W-1:0] rd_nxt;

  // Counter order matches rd_sel and ovf: cycles, instructions, then events.
  assign inc         = {evt, instr_retire, 1'b1};
  assign done_edge   = done & ~done_q;
  assign clock_count = cnt[0];
  assign instr_cnt   = cnt[1];

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = start ? RUN : IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (done_edge) state_nxt = FROZEN;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      running <= 1'b0;
      frozen  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == RUN);
      frozen  <= (state_nxt == FROZEN);
      done_q  <= done;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCNT; k++) cnt[k] <= '0;
      ovf <= '0;
    end else if (clear) begin
      for (int k = 0; k < NCNT; k++) cnt[k] <= '0;
      ovf <= '0;
    end else if (state == RUN) begin
      for (int k = 0; k < NCNT; k++) begin
        if (inc[k]) begin
          if (&cnt[k]) begin
`ifdef PERF_SATURATE_EN
            cnt[k] <= cnt[k];
`else
            cnt[k] <= '0;
`endif
            ovf[k] <= 1'b1;
          end else begin
            cnt[k] <= cnt[k] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Out-of-range selects read as zero.
  always_comb begin
    rd_nxt = '0;
    for (int k = 0; k < NCNT; k++) begin
      if (rd_sel == SEL_W'(k)) rd_nxt = cnt[k];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= rd_nxt;
  end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Scoreboard bench for perf_counter_unit: a 16-bit/4-event instance and a 4-bit/1-event instance for overflow.
module tb_perf_counter_unit;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        start, done, instr_retire, clear;
  logic [3:0]  evt;
  logic [2:0]  rd_sel;
  logic [15:0] rd_data, clock_count, instr_cnt;
  logic        running, frozen;
  logic [5:0]  ovf;

  logic        start4, done4, instr4, clear4;
  logic [0:0]  evt4;
  logic [1:0]  rd_sel4;
  logic [3:0]  rd_data4, clock_count4, instr_cnt4;
  logic        running4, frozen4;
  logic [2:0]  ovf4;

  always #5 CLOCK_50 = ~CLOCK_50;

  perf_counter_unit #(.CNT_W(16), .NUM_EVT(4), .SEL_W(3)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .done(done),
    .instr_retire(instr_retire), .evt(evt), .clear(clear), .rd_sel(rd_sel),
    .rd_data(rd_data), .clock_count(clock_count), .instr_cnt(instr_cnt),
    .running(running), .frozen(frozen), .ovf(ovf)
  );

  perf_counter_unit #(.CNT_W(4), .NUM_EVT(1), .SEL_W(2)) dut4 (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start4), .done(done4),
    .instr_retire(instr4), .evt(evt4), .clear(clear4), .rd_sel(rd_sel4),
    .rd_data(rd_data4), .clock_count(clock_count4), .instr_cnt(instr_cnt4),
    .running(running4), .frozen(frozen4), .ovf(ovf4)
  );

  typedef struct {
    int          due;
    int          sig;
    logic [15:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  event  chk_ev;

  always @(posedge CLOCK_50) cyc = cyc + 1;

  function automatic logic [15:0] probe(input int sig);
    case (sig)
      0:       return clock_count;
      1:       return instr_cnt;
      2:       return {15'd0, running};
      3:       return {15'd0, frozen};
      4:       return {10'd0, ovf};
      5:       return rd_data;
      6:       return {12'd0, clock_count4};
      7:       return {13'd0, ovf4};
      default: return 16'hdead;
    endcase
  endfunction

  task automatic expect_at(input int due, input int sig, input logic [15:0] exp, input string name);
    item_t it;
    it.due = due; it.sig = sig; it.exp = exp; it.name = name;
    sb.push_back(it);
  endtask

  task automatic run_checks();
    item_t       keep[$];
    logic [15:0] act;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].due == cyc) begin
        act = probe(sb[i].sig);
        total++;
        if (act !== sb[i].exp) begin
          bad++;
          $display("FAIL %s: got %0d required %0d (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
        end
      end else if (sb[i].due < cyc) begin
        total++;
        bad++;
        $display("FAIL %s: never sampled (due %0d, now %0d)", sb[i].name, sb[i].due, cyc);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  endtask

  // Monitor: sample at the falling edge, or immediately on request for asynchronous effects.
  initial begin
    forever begin
      @(negedge CLOCK_50 or chk_ev);
      run_checks();
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  logic [15:0] rd_exp [8];

  initial begin
    reset_n = 1'b0; start = 0; done = 0; instr_retire = 0; clear = 0; evt = '0; rd_sel = '0;
    start4 = 0; done4 = 0; instr4 = 0; clear4 = 0; evt4 = '0; rd_sel4 = '0;

    // Reset state
    step(2);
    expect_at(cyc, 0, 16'd0, "rst_cycles");
    expect_at(cyc, 1, 16'd0, "rst_instr");
    expect_at(cyc, 2, 16'd0, "rst_running");
    expect_at(cyc, 3, 16'd0, "rst_frozen");
    expect_at(cyc, 4, 16'd0, "rst_ovf");
    expect_at(cyc, 5, 16'd0, "rst_rd_data");
    reset_n = 1'b1;
    step(2);
    expect_at(cyc, 2, 16'd0, "idle_running");
    expect_at(cyc, 3, 16'd0, "idle_frozen");
    expect_at(cyc, 0, 16'd0, "idle_cycles");

    // Basic run: 10 RUN cycles, instr on odd ones, done rises on the 10th
    start = 1'b1;
    step(1);
    expect_at(cyc, 2, 16'd1, "run_running");
    for (int i = 1; i <= 10; i++) begin
      start        = 1'b0;
      instr_retire = i[0];
      done         = (i == 10);
      step(1);
    end
    instr_retire = 1'b0;
    expect_at(cyc, 0, 16'd10, "basic_cycles");
    expect_at(cyc, 1, 16'd5,  "basic_instr");
    expect_at(cyc, 3, 16'd1,  "basic_frozen");
    expect_at(cyc, 2, 16'd0,  "basic_running");
    step(20);
    expect_at(cyc, 0, 16'd10, "hold_cycles");
    expect_at(cyc, 1, 16'd5,  "hold_instr");

    // Start alone in FROZEN is ignored
    start = 1'b1;
    step(1);
    start = 1'b0;
    expect_at(cyc, 0, 16'd10, "frz_start_cycles");
    expect_at(cyc, 3, 16'd1,  "frz_start_frozen");

    // Clear & start together: restart from zero
    done  = 1'b0;
    clear = 1'b1; start = 1'b1;
    step(1);
    clear = 1'b0; start = 1'b0;
    expect_at(cyc, 0, 16'd0, "restart_cycles");
    expect_at(cyc, 1, 16'd0, "restart_instr");
    expect_at(cyc, 4, 16'd0, "restart_ovf");
    expect_at(cyc, 2, 16'd1, "restart_running");

    // evt[2] for 7 RUN cycles, then freeze (done-edge cycle counted)
    evt = 4'b0100;
    step(7);
    evt  = 4'b0000;
    done = 1'b1;
    step(1);
    expect_at(cyc, 3, 16'd1, "evt_frozen");
    expect_at(cyc, 4, 16'd0, "evt_ovf");
    rd_exp = '{16'd8, 16'd0, 16'd0, 16'd0, 16'd7, 16'd0, 16'd0, 16'd0};
    for (int s = 0; s < 8; s++) begin
      rd_sel = 3'(s);
      expect_at(cyc + 1, 5, rd_exp[s], $sformatf("rd_sel%0d", s));
      step(1);
    end

    // Asynchronous reset mid-run at count 6
    done  = 1'b0;
    clear = 1'b1; start = 1'b1;
    step(1);
    clear = 1'b0; start = 1'b0;
    step(6);
    expect_at(cyc, 0, 16'd6, "pre_rst_cycles");
    @(negedge CLOCK_50);
    #1;
    reset_n = 1'b0;
    #1;
    expect_at(cyc, 0, 16'd0, "async_rst_cycles");
    expect_at(cyc, 2, 16'd0, "async_rst_running");
    -> chk_ev;
    step(2);
    reset_n = 1'b1;
    step(2);
    expect_at(cyc, 0, 16'd0, "post_rst_cycles");
    expect_at(cyc, 2, 16'd0, "post_rst_running");
    expect_at(cyc, 3, 16'd0, "post_rst_frozen");

    // 4-bit counters: 17 RUN cycles overflow the cycle counter
    start4 = 1'b1;
    step(1);
    start4 = 1'b0;
    step(17);
`ifdef PERF_SATURATE_EN
    expect_at(cyc, 6, 16'd15, "cnt4_cycles");
`else
    expect_at(cyc, 6, 16'd1, "cnt4_cycles");
`endif
    expect_at(cyc, 7, 16'd1, "cnt4_ovf");

    step(3);
    for (int i = 0; i < sb.size(); i++) begin
      total++;
      bad++;
      $display("FAIL %s: left unchecked", sb[i].name);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
